bin_to_gray: RTL and testbench
==============================

# bin_to_gray

Registered N-bit binary-to-Gray-code converter. Takes a binary word on a valid-qualified input and presents the reflected Gray code one clock later. Used ahead of clock-domain crossings and position encoders, where adjacent count values must differ in exactly one bit. An optional compiled-in round-trip checker decodes the output back to binary and flags mismatches.

## Interface
- WIDTH, default 4, width of the binary input and Gray output, minimum 1.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies B; conversion is captured only when high.
- B  input  WIDTH  binary operand.
- out_valid  output  1  high for one cycle for each accepted input.
- G  output  WIDTH  registered Gray code of the last accepted B.
- err  output  1  round-trip mismatch flag; driven only when the checker is compiled in.

## Operation
- Conversion rule:
  - G[WIDTH-1] = B[WIDTH-1].
  - G[i] = B[i+1] XOR B[i] for i = WIDTH-2 down to 0.
  - Equivalently, G = B XOR (B >> 1) with a logical shift.
- Pure bitwise mapping: no arithmetic, no carries, no saturation. All 2^WIDTH inputs are legal.
- in_valid high: G ← code(B) and out_valid ← 1 at the next rising edge.
- in_valid low: G holds its previous value and out_valid ← 0.
- Wrap-around: B = all-ones maps to G = 1 followed by zeros (1000 for WIDTH=4). The next value, B = 0, gives G = 0000, still a single-bit change.
- WIDTH = 1: G = B.

## Timing
- Latency is exactly 1 cycle from a sampled in_valid/B to out_valid/G.
- Throughput is one conversion per cycle; back-to-back valids are accepted with no bubbles.
- No backpressure; out_valid is a one-cycle pulse per accepted input.
- Reset values: G = 0, out_valid = 0, err = 0.
- rst has priority over in_valid. An input presented in the same cycle as rst is dropped.
- Reset mid-stream clears the outputs at the next edge. The first post-reset output appears 1 cycle after the first in_valid sampled with rst low.
- No combinational path from any input to any output.

## Configuration
- Macro: BIN_TO_GRAY_ROUNDTRIP_EN.
- Defined:
  - A registered copy of the accepted B is kept alongside G.
  - G is decoded back to binary: b[WIDTH-1] = G[WIDTH-1]; b[i] = b[i+1] XOR G[i].
  - The decoded value is compared combinationally with the stored B.
  - err is registered and asserts 1 cycle after out_valid for any mismatch. err is cleared by rst and is sticky until rst.
- Undefined: no checker logic; err is tied to 0.

## Structure
- Shared package bin_to_gray_pkg holds:
  - the default width constant GRAY_WIDTH_DEFAULT = 4;
  - pure functions bin2gray(b) and gray2bin(g), sized by a parameterised width.
- One sub-module, gray_to_bin: combinational decoder with parameter WIDTH, input G, output B. It is instantiated only under BIN_TO_GRAY_ROUNDTRIP_EN.
- The top level holds the input/output registers, valid pipeline and err register.

## Test plan
- Reset and single conversions: assert rst 2 cycles, check G=0000 and out_valid=0. Then present B=0000, 0101, 1000, 1111 with in_valid=1 → G=0000, 0111, 1100, 1000 respectively, each 1 cycle after its input.
- Full sweep: B = 0..15 back-to-back with in_valid=1 → G sequence 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000. out_valid stays high; consecutive G values, including 1000→0000 on wrap, differ in exactly one bit.
- Hold: after B=0110 is accepted (G=0101), drop in_valid and change B to 1001 → G stays 0101 and out_valid=0.
- Reset priority: rst=1 with in_valid=1, B=1111 → next cycle G=0000, out_valid=0. Release rst and present B=0011 → G=0010 one cycle later.
- WIDTH=8: B=8'hFF → G=8'h80; B=8'hA5 → G=8'hF7.
- With BIN_TO_GRAY_ROUNDTRIP_EN defined: run the full sweep → err stays 0. Force one corrupted G bit in simulation → err=1 on the following cycle and remains 1 until rst.

Source files
------------

// File: rtl/bin_to_gray_pkg.sv
// ---------------------------------------------------------------------------
// bin_to_gray_pkg
//
// Purpose:
//   Shared definitions for the binary-to-Gray converter slice:
//     - GRAY_WIDTH_DEFAULT : default operand width of bin_to_gray.
//     - GRAY_MAX_WIDTH     : widest operand the helper functions handle.
//     - gray_word_t        : fixed-width carrier type for the helpers.
//     - bin2gray / gray2bin: pure reference conversions.
//
// Ports: none (package).
//
// Narrower operands are zero-extended into gray_word_t by the caller.
// Both conversions are insensitive to leading zeros, so the low WIDTH bits
// of the result are the WIDTH-bit answer.
// ---------------------------------------------------------------------------
package bin_to_gray_pkg;

    localparam int GRAY_WIDTH_DEFAULT = 4;
    localparam int GRAY_MAX_WIDTH     = 64;

    typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

    // Reflected Gray code: each bit is the XOR of itself and its upper
    // neighbour; the MSB passes straight through because the shift
    // brings in a zero.
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Inverse mapping: a running XOR from the MSB downwards.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b = '0;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// ---------------------------------------------------------------------------
// gray_to_bin
//
// Purpose:
//   Purely combinational Gray-to-binary decoder. Used by bin_to_gray's
//   round-trip checker to decode the registered Gray output.
//
// Parameters:
//   WIDTH : operand width, minimum 1.
//
// Ports:
//   G : input  [WIDTH-1:0]  Gray-coded word.
//   B : output [WIDTH-1:0]  decoded binary word.
// ---------------------------------------------------------------------------
module gray_to_bin
    import bin_to_gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] G,
    output logic [WIDTH-1:0] B
);

    // Each binary bit is the parity of all Gray bits at or above it, built
    // as a ripple from the MSB. For WIDTH = 1 the loop is empty and B = G.
    always_comb begin
        B = '0;
        B[WIDTH-1] = G[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            B[i] = B[i+1] ^ G[i];
        end
    end

endmodule

// File: rtl/bin_to_gray.sv
// ---------------------------------------------------------------------------
// bin_to_gray
//
// Purpose:
//   Registered WIDTH-bit binary to reflected-Gray converter. An accepted
//   input (in_valid high) appears as Gray code on G one clock later with a
//   one-cycle out_valid pulse. G holds its value while in_valid is low.
//
// Parameters:
//   WIDTH : operand width, default GRAY_WIDTH_DEFAULT, range 1..GRAY_MAX_WIDTH.
//
// Ports:
//   clk       : input         clock, all state on rising edge.
//   rst       : input         synchronous active-high reset (beats in_valid).
//   in_valid  : input         qualifies B.
//   B         : input  [W]    binary operand.
//   out_valid : output        one-cycle pulse per accepted input.
//   G         : output [W]    registered Gray code of last accepted B.
//   err       : output        sticky round-trip mismatch flag.
//
// Configuration:
//   BIN_TO_GRAY_ROUNDTRIP_EN : when defined, a copy of the accepted B is
//   registered next to G, G is decoded back through gray_to_bin, and any
//   disagreement while out_valid is high sets err on the following edge.
//   err then stays high until rst. When undefined, err is tied low and no
//   checker logic exists.
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// ---------------------------------------------------------------------------
module bin_to_gray
    import bin_to_gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] G,
    output logic             err
);

    logic [WIDTH-1:0] gray_next;
    logic [WIDTH-1:0] g_q;
    logic             out_valid_q;

    // The package helper works on the widest word; zero-extending B and
    // truncating back is exact because leading zeros stay zero in Gray code.
    assign gray_next = WIDTH'(bin2gray(gray_word_t'(B)));

    // Output register and valid pipeline. Reset wins over a coincident
    // in_valid, so that input is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                g_q <= gray_next;
            end
        end
    end

    assign G         = g_q;
    assign out_valid = out_valid_q;

`ifdef BIN_TO_GRAY_ROUNDTRIP_EN

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] decoded_b;
    logic             mismatch;
    logic             err_q;

    // Shadow copy of the accepted operand, captured on the same edge as G
    // so the two always describe the same transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q <= '0;
        end else if (in_valid) begin
            b_q <= B;
        end
    end

    gray_to_bin #(
        .WIDTH(WIDTH)
    ) u_decode (
        .G(g_q),
        .B(decoded_b)
    );

    // Only compare while the output is live; otherwise G and b_q are
    // merely holding and have already been checked.
    assign mismatch = out_valid_q && (decoded_b != b_q);

    // Sticky error: once set, only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (mismatch) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

`else

    assign err = 1'b0;

`endif

endmodule

// File: tb/tb_bin_to_gray.sv
// ---------------------------------------------------------------------------
// tb_bin_to_gray
//
// Drives three instances of bin_to_gray (WIDTH = 4, 8 and 1) from shared
// clk/rst/in_valid. Expected Gray codes come from a table built by the
// reflect-and-prefix construction of the Gray sequence, and a small
// transaction model tracks G/out_valid/err for each instance.
// Optional: BIN_TO_GRAY_ROUNDTRIP_EN enables the error-injection section.
// ---------------------------------------------------------------------------
module tb_bin_to_gray;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] b4;
    logic [7:0] b8;
    logic [0:0] b1;

    logic       out_valid4, err4;
    logic [3:0] g4;
    logic       out_valid8, err8;
    logic [7:0] g8;
    logic       out_valid1, err1;
    logic [0:0] g1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reflected Gray sequence: gray_tab[n] is the n-th Gray code word.
    int unsigned gray_tab [256];

    // Model state per instance.
    logic [3:0] exp_g4;
    logic [7:0] exp_g8;
    logic [0:0] exp_g1;
    logic       exp_v;
    logic       exp_err;

    always #5 clk = ~clk;

    bin_to_gray #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .B(b4),
        .out_valid(out_valid4), .G(g4), .err(err4)
    );

    bin_to_gray #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .B(b8),
        .out_valid(out_valid8), .G(g8), .err(err8)
    );

    bin_to_gray #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .B(b1),
        .out_valid(out_valid1), .G(g1), .err(err1)
    );

    // Builds the sequence by reflection: the second half of each doubling
    // is the first half reversed with the new top bit set.
    task automatic build_table();
        gray_tab[0] = 0;
        gray_tab[1] = 1;
        for (int k = 1; k < 8; k++) begin
            for (int j = 0; j < (1 << k); j++) begin
                gray_tab[(1 << k) + j] = (1 << k) | gray_tab[(1 << k) - 1 - j];
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle at the falling edge, advance the model, then settle
    // just past the rising edge.
    task automatic apply_stimulus(input logic r, input logic v,
                                  input logic [3:0] x4, input logic [7:0] x8,
                                  input logic [0:0] x1);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        b4       = x4;
        b8       = x8;
        b1       = x1;
        if (r) begin
            exp_g4  = '0;
            exp_g8  = '0;
            exp_g1  = '0;
            exp_v   = 1'b0;
            exp_err = 1'b0;
        end else if (v) begin
            exp_g4 = 4'(gray_tab[x4]);
            exp_g8 = 8'(gray_tab[x8]);
            exp_g1 = 1'(gray_tab[x1]);
            exp_v  = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic r, input logic v, input logic [3:0] x4);
        apply_stimulus(r, v, x4, 8'($urandom), 1'($urandom));
    endtask

    task automatic check_output(input string tag);
        check_val({tag, "_g4"},  32'(g4),  32'(exp_g4));
        check_val({tag, "_v4"},  32'(out_valid4), 32'(exp_v));
        check_val({tag, "_e4"},  32'(err4), 32'(exp_err));
        check_val({tag, "_g8"},  32'(g8),  32'(exp_g8));
        check_val({tag, "_v8"},  32'(out_valid8), 32'(exp_v));
        check_val({tag, "_e8"},  32'(err8), 32'(exp_err));
        check_val({tag, "_g1"},  32'(g1),  32'(exp_g1));
        check_val({tag, "_v1"},  32'(out_valid1), 32'(exp_v));
        check_val({tag, "_e1"},  32'(err1), 32'(exp_err));
    endtask

    logic [3:0] prev_g;
    logic [3:0] single_b [4];

    initial begin
        build_table();
        rst = 1'b1; in_valid = 1'b0; b4 = '0; b8 = '0; b1 = '0;
        exp_g4 = '0; exp_g8 = '0; exp_g1 = '0; exp_v = 1'b0; exp_err = 1'b0;

        // Reset held for two cycles.
        step4(1'b1, 1'b0, 4'h0);
        step4(1'b1, 1'b0, 4'h0);
        check_output("reset");

        // Single conversions, with literal targets as well as the model.
        single_b[0] = 4'b0000; single_b[1] = 4'b0101;
        single_b[2] = 4'b1000; single_b[3] = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step4(1'b0, 1'b1, single_b[i]);
            check_output("single");
        end
        check_val("single_last_lit", 32'(g4), 32'h8);

        // Full sweep, back-to-back, plus wrap to 0; one bit changes per step.
        step4(1'b0, 1'b1, 4'd0);
        check_output("sweep");
        prev_g = g4;
        for (int i = 1; i <= 16; i++) begin
            step4(1'b0, 1'b1, 4'(i));
            check_output("sweep");
            check_val("sweep_onebit", 32'($countones(g4 ^ prev_g)), 32'd1);
            prev_g = g4;
        end

        // Hold: accept 0110, then drop valid while B changes.
        step4(1'b0, 1'b1, 4'b0110);
        check_val("hold_lit", 32'(g4), 32'h5);
        step4(1'b0, 1'b0, 4'b1001);
        check_output("hold");
        step4(1'b0, 1'b0, 4'b1111);
        check_output("hold2");

        // Reset priority over a coincident valid input.
        step4(1'b1, 1'b1, 4'b1111);
        check_output("rstprio");
        step4(1'b0, 1'b1, 4'b0011);
        check_output("post_rst");
        check_val("post_rst_lit", 32'(g4), 32'h2);

        // WIDTH=8 literal points.
        apply_stimulus(1'b0, 1'b1, 4'h3, 8'hFF, 1'b1);
        check_output("w8_ff");
        check_val("w8_ff_lit", 32'(g8), 32'h80);
        apply_stimulus(1'b0, 1'b1, 4'h7, 8'hA5, 1'b0);
        check_output("w8_a5");
        check_val("w8_a5_lit", 32'(g8), 32'hF7);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(($urandom_range(0, 19) == 0), 1'($urandom),
                           4'($urandom), 8'($urandom), 1'($urandom));
            check_output("rand");
        end

`ifdef BIN_TO_GRAY_ROUNDTRIP_EN
        // Corrupt G while out_valid is live: err rises next edge and sticks.
        step4(1'b1, 1'b0, 4'h0);
        step4(1'b0, 1'b1, 4'd3);
        check_output("inj_pre");
        force dut.g_q = 4'b0011;
        step4(1'b0, 1'b0, 4'h0);
        check_val("inj_err_set", 32'(err4), 32'd1);
        release dut.g_q;
        for (int i = 0; i < 3; i++) begin
            step4(1'b0, 1'b0, 4'h0);
            check_val("inj_err_sticky", 32'(err4), 32'd1);
        end
        step4(1'b1, 1'b0, 4'h0);
        check_output("inj_cleared");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
